dmem_responder: RTL and testbench

- Data-memory responder: the slave end of the CPU load/store interface.
- Accepts one request at a time (address, MemOP, write data, write enable) over a valid/ready handshake and applies RV32 byte/half/word lane rules.
- Holds a word-organised RAM and returns sign- or zero-extended load data after a programmable latency; malformed or out-of-range requests get an error response.
- Replaces the combinational memory model so the core can be exercised against multi-cycle memory.

---
 rtl/dmem_pkg.sv | 44 ++++
 rtl/dmem_lane.sv | 61 ++++++
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MemOP codes, FSM states
// and the request legality checks used by the lane logic.
package dmem_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic mop_illegal(input logic wen, input logic [2:0] op);
        logic bad;
        if (wen) begin
            case (op)
                MOP_B, MOP_H, MOP_W: bad = 1'b0;
                default:             bad = 1'b1;
            endcase
        end else begin
            case (op)
                MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU: bad = 1'b0;
                default:                             bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    // Width comes from op[1:0]; bytes can sit anywhere, halves need an even offset.
    function automatic logic mop_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic bad;
        case (op[1:0])
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for RV32 loads/stores: store byte enables and replicated
// store data, extended load data, and misalignment/illegal-op flags.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic        wen_i,
    input  logic [2:0]  memop_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] load_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [31:0] rsh_s;

    assign rsh_s      = rword_i >> {off_i, 3'b000};
    assign misalign_o = mop_misaligned(memop_i, off_i);
    assign illegal_o  = mop_illegal(wen_i, memop_i);

    // Store side: replicate the source bytes across the word so the byte enables pick the lanes.
    always_comb begin
        be_o    = 4'b0000;
        wword_o = wdata_i;
        case (memop_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off_i;
                wword_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << off_i;
                wword_o = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                be_o    = 4'b1111;
                wword_o = wdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wword_o = wdata_i;
            end
        endcase
    end

    // Load side: extract the addressed lane and sign- or zero-extend it.
    always_comb begin
        load_o = 32'd0;
        case (memop_i)
            MOP_B:   load_o = {{24{rsh_s[7]}}, rsh_s[7:0]};
            MOP_H:   load_o = {{16{rsh_s[15]}}, rsh_s[15:0]};
            MOP_W:   load_o = rword_i;
            MOP_BU:  load_o = {24'd0, rsh_s[7:0]};
            MOP_HU:  load_o = {16'd0, rsh_s[15:0]};
            default: load_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding valid/ready slave holding a
// word-organised RAM, answering after LATENCY extra cycles with an error flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [2:0]  req_memop,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT        = 4'(LATENCY);
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH) << 2;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic        wen_q;
    logic [2:0]  op_q;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] ram [DEPTH];

    logic [31:0] offset_s;
    logic [AW-1:0] widx_s;
    logic        in_range_s, err_s, commit_s, accept_s;
    logic [3:0]  be_s;
    logic [31:0] wword_s, load_s, rword_s;
    logic        misalign_s, illegal_s;

    // Modulo subtraction folds addr < BASE into a huge offset, so one compare covers both bounds.
    assign offset_s   = addr_q - BASE;
    assign in_range_s = ({1'b0, offset_s} < SPAN_BYTES);
    assign widx_s     = offset_s[AW+1:2];
    assign rword_s    = ram[widx_s];
    assign err_s      = !in_range_s || misalign_s || illegal_s;
    assign accept_s   = req_valid && (state_q == IDLE);
    assign commit_s   = (state_q == RESP) && !rsp_valid_q;

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;

    dmem_lane u_lane (
        .wen_i      (wen_q),
        .memop_i    (op_q),
        .off_i      (offset_s[1:0]),
        .wdata_i    (wdata_q),
        .rword_i    (rword_s),
        .be_o       (be_s),
        .wword_o    (wword_s),
        .load_o     (load_s),
        .misalign_o (misalign_s),
        .illegal_o  (illegal_s)
    );

    // Next-state and response logic; the first RESP cycle is the commit edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d   = LAT;
                    state_d = (LAT != 4'd0) ? WAIT : RESP;
                end else begin
                    cnt_d = 4'd0;
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    err_d       = err_s;
                    rdata_d     = (err_s || wen_q) ? 32'd0 : load_s;
                end else if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rdata_d     = 32'd0;
                    err_d       = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = 4'd0;
                rsp_valid_d = 1'b0;
                rdata_d     = 32'd0;
                err_d       = 1'b0;
            end
        endcase
    end

    // FSM, counter and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Request capture on acceptance; held stable for the whole transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= 32'd0;
            wen_q   <= 1'b0;
            op_q    <= 3'd0;
            wdata_q <= 32'd0;
        end else if (accept_s) begin
            addr_q  <= req_addr;
            wen_q   <= req_wen;
            op_q    <= req_memop;
            wdata_q <= req_wdata;
        end
    end

    // RAM write port, active only on the commit edge of a clean store.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (commit_s && wen_q && !err_s && be_s[b]) begin
                ram[widx_s][8*b +: 8] <= wword_s[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 1, 0, 3) checked
// every cycle against a byte-addressed memory model and literal expectations.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT [3] = '{1, 0, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [3];
    logic        req_ready [3];
    logic [31:0] req_addr  [3];
    logic        req_wen   [3];
    logic [2:0]  req_memop [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0]  mem_m [bit [33:0]];
    bit          pend  [3];
    int          age   [3];
    int          hold  [3];
    logic [31:0] e_rd  [3];
    bit          e_err [3];
    bit          lit_en  [3];
    logic [31:0] lit_rd  [3];
    bit          lit_err [3];
    bit          w_pend  [3];
    int          w_size  [3];
    logic [31:0] w_addr  [3];
    logic [31:0] w_data  [3];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_wen(req_wen[0]), .req_memop(req_memop[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    dmem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_wen(req_wen[1]), .req_memop(req_memop[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    dmem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr[2]), .req_wen(req_wen[2]), .req_memop(req_memop[2]),
        .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] rd_b(input int k, input logic [31:0] a);
        bit [33:0] key;
        key = {k[1:0], a};
        return mem_m.exists(key) ? mem_m[key] : 8'h00;
    endfunction

    // Memory seen as little-endian bytes; legality from width, range and alignment.
    task automatic predict(input int k, input bit wen, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int          size;
        bit          legal, inr, al;
        logic [31:0] v, mask;
        size  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        legal = wen ? (op inside {3'd0, 3'd1, 3'd2}) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        inr   = (longint'(addr) >= longint'(BASE)) && (longint'(addr) < longint'(BASE) + 4 * DEPTH);
        al    = (addr % size) == 0;
        e_err[k]  = !(legal && inr && al);
        e_rd[k]   = 32'd0;
        w_pend[k] = 1'b0;
        if (!e_err[k] && !wen) begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(rd_b(k, addr + i)) << (8 * i));
            mask = (size == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
            if (!op[2] && size < 4 && v[8*size-1]) v = v | ~mask;
            e_rd[k] = v;
        end
        if (!e_err[k] && wen) begin
            w_pend[k] = 1'b1;
            w_size[k] = size;
            w_addr[k] = addr;
            w_data[k] = wdata;
        end
    endtask

    // Per-cycle comparison of every instance against the model's expected timeline.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                if (pend[k]) begin
                    bit ev;
                    age[k]++;
                    ev = (age[k] >= 2 + LAT[k]);
                    check($sformatf("rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'(ev));
                    check($sformatf("req_ready_busy[%0d]", k), 32'(req_ready[k]), 32'd0);
                    if (ev) begin
                        if (w_pend[k]) begin
                            for (int i = 0; i < w_size[k]; i++)
                                mem_m[{k[1:0], w_addr[k] + i}] = w_data[k][8*i +: 8];
                            w_pend[k] = 1'b0;
                        end
                        check($sformatf("rsp_rdata[%0d]", k), rsp_rdata[k], e_rd[k]);
                        check($sformatf("rsp_err[%0d]", k), 32'(rsp_err[k]), 32'(e_err[k]));
                        if (lit_en[k]) begin
                            check($sformatf("lit_rdata[%0d]", k), rsp_rdata[k], lit_rd[k]);
                            check($sformatf("lit_err[%0d]", k), 32'(rsp_err[k]), 32'(lit_err[k]));
                        end
                        if (hold[k] > 0) begin
                            hold[k]--;
                            rsp_ready[k] = 1'b0;
                        end else begin
                            rsp_ready[k] = 1'b1;
                            pend[k]      = 1'b0;
                        end
                    end
                end else begin
                    check($sformatf("idle_rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'd0);
                    check($sformatf("idle_req_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
                    rsp_ready[k] = 1'b0;
                end
            end
        end
    end

    task automatic issue(input int k, input bit wen, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit le = 1'b0, input logic [31:0] lrd = 32'd0,
                         input bit lerr = 1'b0, input int hd = 0);
        int guard = 0;
        @(negedge clk); #1;
        while ((pend[k] || !req_ready[k]) && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            n_vec++;
            n_fail++;
            $display("FAIL issue_timeout[%0d]: req_ready still %0d, expected 1", k, req_ready[k]);
            return;
        end
        predict(k, wen, op, addr, wdata);
        lit_en[k]  = le;
        lit_rd[k]  = lrd;
        lit_err[k] = lerr;
        hold[k]    = hd;
        age[k]     = 0;
        pend[k]    = 1'b1;
        req_valid[k] = 1'b1;
        req_wen[k]   = wen;
        req_memop[k] = op;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        req_memop[k] = 3'($urandom_range(0, 7));
        req_wen[k]   = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int guard = 0;
        while ((pend[0] || pend[1] || pend[2]) && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        if (guard >= 200) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: pending %0d%0d%0d, expected 000", pend[0], pend[1], pend[2]);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_addr[k] = 32'd0; req_wen[k] = 1'b0;
            req_memop[k] = 3'd0; req_wdata[k] = 32'd0; rsp_ready[k] = 1'b0;
            pend[k] = 1'b0; w_pend[k] = 1'b0; hold[k] = 0; age[k] = 0; lit_en[k] = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'd0);
            check($sformatf("reset_rsp_rdata[%0d]", k), rsp_rdata[k], 32'd0);
            check($sformatf("reset_rsp_err[%0d]", k), 32'(rsp_err[k]), 32'd0);
            check($sformatf("reset_req_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        // LATENCY=1: store/load, sub-word loads, lane writes
        issue(0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b0);
        issue(0, 1'b0, 3'b010, 32'h8000_0004, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0);
        issue(0, 1'b0, 3'b000, 32'h8000_0007, 32'h0,         1'b1, 32'hFFFF_FFDE, 1'b0);
        issue(0, 1'b0, 3'b100, 32'h8000_0007, 32'h0,         1'b1, 32'h0000_00DE, 1'b0);
        issue(0, 1'b0, 3'b001, 32'h8000_0006, 32'h0,         1'b1, 32'hFFFF_DEAD, 1'b0);
        issue(0, 1'b0, 3'b101, 32'h8000_0004, 32'h0,         1'b1, 32'h0000_BEEF, 1'b0);
        issue(0, 1'b1, 3'b000, 32'h8000_0005, 32'h0000_0011);
        issue(0, 1'b0, 3'b010, 32'h8000_0004, 32'h0,         1'b1, 32'hDEAD_11EF, 1'b0);
        issue(0, 1'b1, 3'b001, 32'h8000_0006, 32'h0000_1234);
        issue(0, 1'b0, 3'b010, 32'h8000_0004, 32'h0,         1'b1, 32'h1234_11EF, 1'b0);

        // Error cases
        issue(0, 1'b1, 3'b010, 32'h8000_0000, 32'hCAFE_F00D);
        issue(0, 1'b0, 3'b010, 32'h8000_0002, 32'h0,         1'b1, 32'h0000_0000, 1'b1);
        issue(0, 1'b1, 3'b001, 32'h8000_0003, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1);
        issue(0, 1'b0, 3'b010, 32'h8000_0000, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0);
        issue(0, 1'b0, 3'b011, 32'h8000_0000, 32'h0,         1'b1, 32'h0000_0000, 1'b1);
        issue(0, 1'b1, 3'b100, 32'h8000_0000, 32'h0000_0077, 1'b1, 32'h0000_0000, 1'b1);
        issue(0, 1'b0, 3'b010, 32'h7FFF_FFFC, 32'h0,         1'b1, 32'h0000_0000, 1'b1);
        issue(0, 1'b0, 3'b010, 32'h8000_1000, 32'h0,         1'b1, 32'h0000_0000, 1'b1);
        issue(0, 1'b1, 3'b010, 32'h8000_0FFC, 32'h1357_9BDF);
        issue(0, 1'b0, 3'b010, 32'h8000_0FFC, 32'h0,         1'b1, 32'h1357_9BDF, 1'b0);
        issue(0, 1'b0, 3'b010, 32'h8000_0000, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0);

        // Backpressure: response held for five cycles
        issue(0, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 1'b1, 32'h1234_11EF, 1'b0, 5);

        // Reset during WAIT drops the pending store
        issue(0, 1'b1, 3'b010, 32'h8000_0010, 32'h0A0B_0C0D);
        drain();
        issue(0, 1'b1, 3'b010, 32'h8000_0010, 32'h5555_5555);
        check("wait_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("wait_req_ready", 32'(req_ready[0]), 32'd0);
        #1 rst = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("midrst_rsp_rdata", rsp_rdata[0], 32'd0);
        check("midrst_rsp_err", 32'(rsp_err[0]), 32'd0);
        check("midrst_req_ready", 32'(req_ready[0]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            pend[k] = 1'b0; w_pend[k] = 1'b0; rsp_ready[k] = 1'b0;
        end
        @(negedge clk); #1 rst = 1'b1;
        issue(0, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 1'b1, 32'h0A0B_0C0D, 1'b0);

        // LATENCY=0 and LATENCY=3 instances
        issue(1, 1'b1, 3'b010, 32'h8000_0020, 32'hA5C3_5A3C, 1'b1, 32'h0000_0000, 1'b0);
        issue(1, 1'b0, 3'b010, 32'h8000_0020, 32'h0,         1'b1, 32'hA5C3_5A3C, 1'b0);
        issue(1, 1'b0, 3'b001, 32'h8000_0022, 32'h0,         1'b1, 32'hFFFF_A5C3, 1'b0, 2);
        issue(1, 1'b0, 3'b010, 32'h8000_0021, 32'h0,         1'b1, 32'h0000_0000, 1'b1);
        issue(2, 1'b1, 3'b010, 32'h8000_0040, 32'h0102_8384, 1'b1, 32'h0000_0000, 1'b0);
        issue(2, 1'b0, 3'b000, 32'h8000_0040, 32'h0,         1'b1, 32'hFFFF_FF84, 1'b0, 3);
        issue(2, 1'b0, 3'b101, 32'h8000_0042, 32'h0,         1'b1, 32'h0000_0102, 1'b0);
        issue(2, 1'b0, 3'b111, 32'h8000_0040, 32'h0,         1'b1, 32'h0000_0000, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
